drop_engine: RTL



---
 rtl/drops_pkg.sv | 29 ++
 rtl/drop_lfsr.sv | 15 +
 rtl/drop_engine.sv | 124 ++++++++++++
 3 files changed

// File: rtl/drops_pkg.sv
// Shared parameters, slot payload and helpers for the falling-drops game core.
package drops_pkg;

  localparam int unsigned DEF_NUM_DROPS = 4;
  localparam int unsigned DEF_X_W       = 4;
  localparam int unsigned DEF_Y_W       = 4;

  localparam int unsigned LFSR_W    = 8;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;
  // Feedback taps 8,6,5,4 expressed as state bits 7,5,4,3
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

  // Per-tick landing counts; wide enough for up to 8 slots
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic               active;
    logic [DEF_X_W-1:0] x;
    logic [DEF_Y_W-1:0] y;
  } drop_t;

  // 8-bit accumulate that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [CNT_W-1:0] b);
    logic [8:0] sum;
    sum = 9'(a) + 9'(b);
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/drop_lfsr.sv
// Free-running 8-bit Fibonacci LFSR feeding the random spawner.
module drop_lfsr
  import drops_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (rst) state <= LFSR_SEED;
    else     state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/drop_engine.sv
// Drop slot array: moves drops per frame tick, spawns new ones, scores landings
// and answers pipelined per-cell occupancy queries for the renderer.
module drop_engine
  import drops_pkg::*;
#(
  parameter int unsigned NUM_DROPS = DEF_NUM_DROPS,
  parameter int unsigned X_W       = DEF_X_W,
  parameter int unsigned Y_W       = DEF_Y_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           spawn_en,
  input  logic           inj_valid,
  input  logic [X_W-1:0] inj_x,
  input  logic [X_W-1:0] catcher_x,
  input  logic           qry_valid,
  input  logic [X_W-1:0] qry_x,
  input  logic [Y_W-1:0] qry_y,
  output logic           qry_hit,
  output logic           caught,
  output logic           missed,
  output logic [7:0]     score,
  output logic [7:0]     misses
);

  localparam logic [Y_W-1:0] BOTTOM_ROW = '1;

  logic [LFSR_W-1:0]    lfsr;
  logic                 unused_lfsr;
  drop_t                slots_q [NUM_DROPS];
  drop_t                slots_d [NUM_DROPS];
  logic [NUM_DROPS-1:0] land_hit;
  logic [NUM_DROPS-1:0] land_miss;
  logic [CNT_W-1:0]     n_hit;
  logic [CNT_W-1:0]     n_miss;
  logic                 spawn_req;
  logic [X_W-1:0]       spawn_x;
  logic                 slot_taken;
  logic                 qry_match;

  drop_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  // Only the top two bits and the column slice are consumed
  assign unused_lfsr = ^lfsr;

  // Spawn candidate: inject wins over the random spawner
  always_comb begin
    spawn_req = 1'b0;
    spawn_x   = '0;
    if (inj_valid) begin
      spawn_req = 1'b1;
      spawn_x   = inj_x;
    end else if (spawn_en && (lfsr[7:6] == 2'b00)) begin
      spawn_req = 1'b1;
      spawn_x   = lfsr[X_W-1:0];
    end
  end

  // Move active slots; the lowest slot that was free before the tick takes the spawn
  always_comb begin
    slots_d    = slots_q;
    land_hit   = '0;
    land_miss  = '0;
    slot_taken = 1'b0;
    if (tick) begin
      for (int i = 0; i < int'(NUM_DROPS); i++) begin
        if (slots_q[i].active) begin
          if (slots_q[i].y == BOTTOM_ROW) begin
            slots_d[i].active = 1'b0;
            if (slots_q[i].x == catcher_x) land_hit[i]  = 1'b1;
            else                           land_miss[i] = 1'b1;
          end else begin
            slots_d[i].y = slots_q[i].y + Y_W'(1);
          end
        end else if (spawn_req && !slot_taken) begin
          slots_d[i] = '{active: 1'b1, x: spawn_x, y: '0};
          slot_taken = 1'b1;
        end
      end
    end
  end

  always_comb begin
    n_hit  = '0;
    n_miss = '0;
    for (int i = 0; i < int'(NUM_DROPS); i++) begin
      n_hit  = n_hit  + CNT_W'(land_hit[i]);
      n_miss = n_miss + CNT_W'(land_miss[i]);
    end
  end

  // Occupancy lookup against the state before any coincident tick
  always_comb begin
    qry_match = 1'b0;
    for (int i = 0; i < int'(NUM_DROPS); i++) begin
      if (slots_q[i].active && (slots_q[i].x == qry_x) && (slots_q[i].y == qry_y))
        qry_match = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_DROPS); i++) slots_q[i] <= '0;
      score   <= '0;
      misses  <= '0;
      caught  <= 1'b0;
      missed  <= 1'b0;
      qry_hit <= 1'b0;
    end else begin
      slots_q <= slots_d;
      score   <= sat_add8(score, n_hit);
      misses  <= sat_add8(misses, n_miss);
      caught  <= |land_hit;
      missed  <= |land_miss;
      qry_hit <= qry_valid & qry_match;
    end
  end

endmodule
